// File: rtl/difftest_csr_snapshot_fifo.sv
// Purpose: snapshot the architectural CSR state at every instruction commit and
// hold the snapshots in a small FIFO. The difftest CSR-state sink reads the
// snapshot at the head of the FIFO and acknowledges it, so commit timing is
// decoupled from the simulator's sampling cadence.
// Ports:
//   clk, rst_n      core clock (rising edge), asynchronous active-low reset
//   i_commit_valid  commit this cycle; capture i_csr_pack
//   o_commit_ready  FIFO not full
//   i_csr_pack      18 x 64-bit CSR fields, field k at bits [64k+63:64k]
//   i_flush         synchronous clear of all entries (priority over push/pop)
//   o_dt_valid      head snapshot available
//   i_dt_ack        sink consumed the head snapshot
//   o_csr_pack      head snapshot, all zero while empty
//   o_count         current occupancy
//   o_overflow      sticky: a commit arrived while full
module difftest_csr_snapshot_fifo #(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned FIELDS = 18,
   localparam int unsigned PW = FIELDS * 64,
   localparam int unsigned CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_commit_valid,
   output logic          o_commit_ready,
   input  logic [PW-1:0] i_csr_pack,
   input  logic          i_flush,
   output logic          o_dt_valid,
   input  logic          i_dt_ack,
   output logic [PW-1:0] o_csr_pack,
   output logic [CW-1:0] o_count,
   output logic          o_overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned RW = PW - 64;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   // privilegeMode keeps only its two meaningful bits; other fields are verbatim
   logic [1:0]    priv_mem [DEPTH];
   logic [RW-1:0] rest_mem [DEPTH];

   logic full_c, empty_c, push_c, pop_c;
   logic unused_priv_hi;

   assign unused_priv_hi = ^i_csr_pack[63:2];

   // Full/empty come only from the occupancy count; pointers just wrap
   assign full_c  = (count_q == CW'(DEPTH));
   assign empty_c = (count_q == CW'(0));
   assign push_c  = i_commit_valid & ~full_c;
   assign pop_c   = i_dt_ack & ~empty_c;

   // Next-state for pointers, occupancy and the sticky overflow flag
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // A commit refused because of full is an overflow even during a flush
      ovf_d    = ovf_q | (i_commit_valid & full_c);
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_c) - CW'(pop_c);
      end
   end

   // Control state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Snapshot storage, deliberately not reset
   always_ff @(posedge clk) begin
      if (push_c && !i_flush) begin
         priv_mem[wr_ptr_q] <= i_csr_pack[1:0];
         rest_mem[wr_ptr_q] <= i_csr_pack[PW-1:64];
      end
   end

   // Head read and status, combinational from registered state only
   assign o_commit_ready = ~full_c;
   assign o_dt_valid     = ~empty_c;
   assign o_count        = count_q;
   assign o_overflow     = ovf_q;
   assign o_csr_pack     = empty_c ? '0
                                   : {rest_mem[rd_ptr_q], 62'b0, priv_mem[rd_ptr_q]};

endmodule

// File: tb/tb_difftest_csr_snapshot_fifo.sv
// Purpose: self-checking bench for difftest_csr_snapshot_fifo (DEPTH=4).
// Drives a table of single-cycle vectors, then multi-cycle sequences for
// streaming with pointer wrap, flush and asynchronous reset.
module tb_difftest_csr_snapshot_fifo;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = 1152;
   localparam int unsigned CW    = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_commit_valid;
   logic          o_commit_ready;
   logic [PW-1:0] i_csr_pack;
   logic          i_flush;
   logic          o_dt_valid;
   logic          i_dt_ack;
   logic [PW-1:0] o_csr_pack;
   logic [CW-1:0] o_count;
   logic          o_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   difftest_csr_snapshot_fifo #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_commit_valid (i_commit_valid),
      .o_commit_ready (o_commit_ready),
      .i_csr_pack     (i_csr_pack),
      .i_flush        (i_flush),
      .o_dt_valid     (o_dt_valid),
      .i_dt_ack       (i_dt_ack),
      .o_csr_pack     (o_csr_pack),
      .o_count        (o_count),
      .o_overflow     (o_overflow)
   );

   typedef struct {
      logic        cv, ack, fl;
      logic [63:0] pi, mi, ei;       // privilegeMode, mstatus, mepc in
      logic [2:0]  cnt;
      logic        v, r, ovf;
      logic [63:0] pe, me, ee;       // expected head fields
   } vec_t;

   vec_t tbl[13];

   // Pack with privilegeMode (field 0), mstatus (field 1), mepc (field 3); rest zero
   function automatic logic [PW-1:0] mk(input logic [63:0] p, input logic [63:0] m,
                                        input logic [63:0] e);
      logic [PW-1:0] v;
      v = '0;
      v[63:0]    = p;
      v[127:64]  = m;
      v[255:192] = e;
      return v;
   endfunction

   function automatic vec_t mkv(input logic cv, input logic ack, input logic fl,
                                input logic [63:0] pi, input logic [63:0] mi,
                                input logic [63:0] ei, input logic [2:0] cnt,
                                input logic v, input logic r, input logic ovf,
                                input logic [63:0] pe, input logic [63:0] me,
                                input logic [63:0] ee);
      vec_t t;
      t.cv = cv; t.ack = ack; t.fl = fl;
      t.pi = pi; t.mi = mi; t.ei = ei;
      t.cnt = cnt; t.v = v; t.r = r; t.ovf = ovf;
      t.pe = pe; t.me = me; t.ee = ee;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_pack(input string nm, input logic [PW-1:0] exp);
      n_checks++;
      if (o_csr_pack !== exp) begin
         n_fail++;
         $display("FAIL %s: got f0=%h f1=%h f3=%h expected f0=%h f1=%h f3=%h", nm,
                  o_csr_pack[63:0], o_csr_pack[127:64], o_csr_pack[255:192],
                  exp[63:0], exp[127:64], exp[255:192]);
      end
   endtask

   // Apply inputs, clock once, sample 1 time unit after the edge
   task automatic cycle(input logic cv, input logic ack, input logic fl,
                        input logic [PW-1:0] pack);
      i_commit_valid = cv;
      i_dt_ack       = ack;
      i_flush        = fl;
      i_csr_pack     = pack;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string nm, input logic [2:0] cnt, input logic v,
                            input logic r, input logic ovf, input logic [PW-1:0] pk);
      chk({nm, " count"},    64'(o_count),        64'(cnt));
      chk({nm, " valid"},    64'(o_dt_valid),     64'(v));
      chk({nm, " ready"},    64'(o_commit_ready), 64'(r));
      chk({nm, " overflow"}, 64'(o_overflow),     64'(ovf));
      chk_pack({nm, " pack"}, pk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // single push / ack, privilegeMode=3, mstatus=0xA00000000
      tbl[0]  = mkv(1,0,0, 64'd3, 64'hA_0000_0000, 64'h0, 3'd1,1,1,0, 64'd3, 64'hA_0000_0000, 64'h0);
      tbl[1]  = mkv(0,1,0, 64'h0, 64'h0, 64'h0, 3'd0,0,1,0, 64'h0, 64'h0, 64'h0);
      // fill with mepc = 0x80000000 + 4i
      tbl[2]  = mkv(1,0,0, 64'd1, 64'h0, 64'h8000_0000, 3'd1,1,1,0, 64'd1, 64'h0, 64'h8000_0000);
      tbl[3]  = mkv(1,0,0, 64'd1, 64'h0, 64'h8000_0004, 3'd2,1,1,0, 64'd1, 64'h0, 64'h8000_0000);
      tbl[4]  = mkv(1,0,0, 64'd1, 64'h0, 64'h8000_0008, 3'd3,1,1,0, 64'd1, 64'h0, 64'h8000_0000);
      tbl[5]  = mkv(1,0,0, 64'd1, 64'h0, 64'h8000_000C, 3'd4,1,0,0, 64'd1, 64'h0, 64'h8000_0000);
      // full: commit + ack -> pop only, overflow set
      tbl[6]  = mkv(1,1,0, 64'd1, 64'h0, 64'hDEAD,      3'd3,1,1,1, 64'd1, 64'h0, 64'h8000_0004);
      tbl[7]  = mkv(0,1,0, 64'h0, 64'h0, 64'h0,         3'd2,1,1,1, 64'd1, 64'h0, 64'h8000_0008);
      tbl[8]  = mkv(0,1,0, 64'h0, 64'h0, 64'h0,         3'd1,1,1,1, 64'd1, 64'h0, 64'h8000_000C);
      tbl[9]  = mkv(0,1,0, 64'h0, 64'h0, 64'h0,         3'd0,0,1,1, 64'h0, 64'h0, 64'h0);
      // ack while empty is ignored
      tbl[10] = mkv(0,1,0, 64'h0, 64'h0, 64'h0,         3'd0,0,1,1, 64'h0, 64'h0, 64'h0);
      // privilegeMode truncated to two bits
      tbl[11] = mkv(1,0,0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h5, 64'h1234, 3'd1,1,1,1, 64'h1, 64'h5, 64'h1234);
      tbl[12] = mkv(0,1,0, 64'h0, 64'h0, 64'h0,         3'd0,0,1,1, 64'h0, 64'h0, 64'h0);

      rst_n = 1'b0;
      i_commit_valid = 1'b0;
      i_dt_ack = 1'b0;
      i_flush = 1'b0;
      i_csr_pack = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_state("reset", 3'd0, 1'b0, 1'b1, 1'b0, '0);

      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].cv, tbl[i].ack, tbl[i].fl, mk(tbl[i].pi, tbl[i].mi, tbl[i].ei));
         chk_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].v, tbl[i].r, tbl[i].ovf,
                   tbl[i].v ? mk(tbl[i].pe, tbl[i].me, tbl[i].ee) : '0);
      end

      // steady stream: one in, one out per cycle, pointers wrap several times
      cycle(1, 0, 0, mk(64'd2, 64'h0, 64'd1000));
      chk_state("stream0", 3'd1, 1'b1, 1'b1, 1'b1, mk(64'd2, 64'h0, 64'd1000));
      for (int k = 1; k <= 20; k++) begin
         cycle(1, 1, 0, mk(64'd2, 64'h0, 64'(1000 + k)));
         chk($sformatf("stream%0d count", k), 64'(o_count), 64'd1);
         chk_pack($sformatf("stream%0d pack", k), mk(64'd2, 64'h0, 64'(1000 + k)));
      end
      cycle(0, 1, 0, '0);
      chk_state("stream_drain", 3'd0, 1'b0, 1'b1, 1'b1, '0);

      // flush with concurrent push and ack, three entries queued
      for (int k = 0; k < 3; k++) cycle(1, 0, 0, mk(64'd0, 64'h0, 64'(2000 + k)));
      chk_state("preflush", 3'd3, 1'b1, 1'b1, 1'b1, mk(64'd0, 64'h0, 64'd2000));
      cycle(1, 1, 1, mk(64'd0, 64'h0, 64'hBAD));
      chk_state("flush", 3'd0, 1'b0, 1'b1, 1'b1, '0);
      cycle(1, 0, 0, mk(64'd3, 64'h7, 64'h3000));
      chk_state("postflush", 3'd1, 1'b1, 1'b1, 1'b1, mk(64'd3, 64'h7, 64'h3000));
      cycle(0, 1, 0, '0);
      chk_state("postflush_drain", 3'd0, 1'b0, 1'b1, 1'b1, '0);

      // asynchronous reset mid-cycle empties immediately and clears overflow
      cycle(1, 0, 0, mk(64'd1, 64'h0, 64'h4000));
      cycle(1, 0, 0, mk(64'd1, 64'h0, 64'h4004));
      i_commit_valid = 1'b0;
      chk("prereset count", 64'(o_count), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_state("async_reset", 3'd0, 1'b0, 1'b1, 1'b0, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle(1, 0, 0, mk(64'd2, 64'h9, 64'h5000));
      chk_state("after_reset", 3'd1, 1'b1, 1'b1, 1'b0, mk(64'd2, 64'h9, 64'h5000));
      cycle(0, 1, 0, '0);
      chk_state("after_reset_drain", 3'd0, 1'b0, 1'b1, 1'b0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
